span_fill_engine: RTL and testbench

Hardware span-fill engine sitting directly downstream of the Nios system's `data_request_export`/`write_switch_export` PIO outputs and feeding its `wdone_export` PIO input. Software packs a horizontal span command (x, y, length, colour) into one 32-bit word and raises a request bit. The engine then writes the span into the selected frame buffer at one pixel per accepted cycle and reports completion through a four-phase handshake. This offloads per-pixel stores from the Nios and frees its memory bandwidth.

---
 rtl/span_fill_pkg.sv | 49 ++++
 rtl/fb_addr_calc.sv | 79 +++++++
 rtl/span_fill_engine.sv | 159 +++++++++++++++
 tb/tb_span_fill_engine.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/span_fill_pkg.sv
// Shared definitions for the span fill engine: FSM states, the layout of
// the packed span command word, wdone status bit positions and default
// frame geometry.
package span_fill_pkg;

  // Engine sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } span_state_e;

  // Span command word field positions
  localparam int CMD_X_LSB   = 0;
  localparam int CMD_X_W     = 10;
  localparam int CMD_Y_LSB   = 10;
  localparam int CMD_Y_W     = 9;
  localparam int CMD_LEN_LSB = 19;
  localparam int CMD_LEN_W   = 8;
  localparam int CMD_COL_LSB = 27;
  localparam int CMD_COL_W   = 5;

  // Status bits reported back to the Nios
  localparam int WDONE_DONE_BIT = 0;
  localparam int WDONE_CLIP_BIT = 1;
  localparam int WDONE_REJ_BIT  = 2;

  // Default frame geometry and frame-buffer address width
  localparam int H_RES_DEFAULT  = 640;
  localparam int V_RES_DEFAULT  = 480;
  localparam int ADDR_W_DEFAULT = 20;

  // Pixel counter width: a span holds at most 256 pixels
  localparam int SPAN_CNT_W = 9;

  // Builds the wdone status byte from its individual flags
  function automatic logic [7:0] pack_status(input logic done,
                                             input logic clipped,
                                             input logic rejected);
    logic [7:0] status;
    status = 8'h00;
    status[WDONE_DONE_BIT] = done;
    status[WDONE_CLIP_BIT] = clipped;
    status[WDONE_REJ_BIT]  = rejected;
    return status;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Span set-up stage: from the latched x, y and length it registers the row
// base address, the number of pixels that actually fit on the row, and the
// clipped / rejected flags. Kept separate so the row-multiply strategy can
// follow the horizontal resolution without touching the sequencing logic.
module fb_addr_calc
  import span_fill_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int BASE_W = ADDR_W_DEFAULT - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [CMD_X_W-1:0]    x_i,
  input  logic [CMD_Y_W-1:0]    y_i,
  input  logic [CMD_LEN_W-1:0]  len_m1_i,
  output logic [BASE_W-1:0]     base_o,
  output logic [SPAN_CNT_W-1:0] eff_len_o,
  output logic                  clipped_o,
  output logic                  rejected_o
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  logic [BASE_W-1:0]     base_d, base_q;
  logic [SPAN_CNT_W-1:0] eff_len_d, eff_len_q;
  logic                  clipped_d, clipped_q;
  logic                  rejected_d, rejected_q;
  logic [10:0]           len_full;
  logic [10:0]           room;

  // A 640-pixel row is 512 + 128, so two shifted adds replace the multiplier;
  // any other width falls back to a plain multiply.
  generate
    if (H_RES == 640) begin : g_shift_add
      assign base_d = (BASE_W'(y_i) << 9) + (BASE_W'(y_i) << 7) + BASE_W'(x_i);
    end else begin : g_mult
      assign base_d = (BASE_W'(y_i) * BASE_W'(H_RES)) + BASE_W'(x_i);
    end
  endgenerate

  // Off-screen start points are rejected; otherwise trim the span to the row end
  always_comb begin
    rejected_d = ({1'b0, x_i} >= H_LIM) || ({1'b0, y_i} >= V_LIM);
    len_full   = 11'(len_m1_i) + 11'd1;
    room       = H_LIM - {1'b0, x_i};
    clipped_d  = 1'b0;
    eff_len_d  = len_full[SPAN_CNT_W-1:0];
    if (rejected_d) begin
      eff_len_d = '0;
    end else if (room < len_full) begin
      clipped_d = 1'b1;
      eff_len_d = room[SPAN_CNT_W-1:0];
    end
  end

  // Capture the set-up results once per span, on the engine's request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      eff_len_q  <= '0;
      clipped_q  <= 1'b0;
      rejected_q <= 1'b0;
    end else if (load_i) begin
      base_q     <= base_d;
      eff_len_q  <= eff_len_d;
      clipped_q  <= clipped_d;
      rejected_q <= rejected_d;
    end
  end

  assign base_o     = base_q;
  assign eff_len_o  = eff_len_q;
  assign clipped_o  = clipped_q;
  assign rejected_o = rejected_q;

endmodule

// File: rtl/span_fill_engine.sv
// Horizontal span filler between the Nios PIO exports and a frame-buffer
// write port. Software packs x, y, length and colour into one word and raises
// a request level; the engine writes one pixel per accepted cycle and reports
// done / clipped / rejected through wdone until the request level drops.
module span_fill_engine
  import span_fill_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_request,
  input  logic [7:0]        write_switch,
  input  logic              buffer_sel,
  input  logic              fb_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              fb_we,
  output logic [7:0]        wdone
);

  localparam int BASE_W = ADDR_W - 1;

  span_state_e           state_q;
  logic [31:0]           cmd_q;
  logic                  sel_q;
  logic                  calc_wait_q;
  logic [SPAN_CNT_W-1:0] i_q;
  logic                  fb_we_q;
  logic [ADDR_W-1:0]     fb_addr_q;
  logic [7:0]            fb_wdata_q;
  logic [7:0]            wdone_q;

  logic [BASE_W-1:0]     base;
  logic [SPAN_CNT_W-1:0] eff_len;
  logic                  clipped;
  logic                  rejected;
  logic                  calc_load;

  logic                  req;
  logic                  accept;
  logic                  last_beat;
  logic [BASE_W-1:0]     next_off_d;
  logic [7:0]            status_d;
  logic                  unused_ok;

  // Only bit 0 of the switch export carries the request level
  assign req       = write_switch[0];
  assign unused_ok = &{1'b0, write_switch[7:1]};

  // The set-up stage loads on the first CALC cycle; results are used on the next
  assign calc_load = (state_q == ST_CALC) && calc_wait_q;

  fb_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .BASE_W (BASE_W)
  ) u_addr_calc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (calc_load),
    .x_i        (cmd_q[CMD_X_LSB +: CMD_X_W]),
    .y_i        (cmd_q[CMD_Y_LSB +: CMD_Y_W]),
    .len_m1_i   (cmd_q[CMD_LEN_LSB +: CMD_LEN_W]),
    .base_o     (base),
    .eff_len_o  (eff_len),
    .clipped_o  (clipped),
    .rejected_o (rejected)
  );

  // Handshake decode, the address of the following pixel and the final status
  always_comb begin
    accept     = fb_we_q & fb_ready;
    last_beat  = (i_q + 1'b1) == eff_len;
    next_off_d = base + BASE_W'(i_q) + BASE_W'(1);
    status_d   = pack_status(1'b1, clipped, rejected);
  end

  // Span sequencer with registered frame-buffer and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      sel_q       <= 1'b0;
      calc_wait_q <= 1'b0;
      i_q         <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      wdone_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          fb_we_q <= 1'b0;
          if (req) begin
            cmd_q       <= data_request;
            sel_q       <= buffer_sel;
            calc_wait_q <= 1'b1;
            state_q     <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (!req) begin
            calc_wait_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (calc_wait_q) begin
            calc_wait_q <= 1'b0;
          end else if (rejected) begin
            wdone_q <= status_d;
            state_q <= ST_DONE;
          end else begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= {sel_q, base};
            fb_wdata_q <= {3'b000, cmd_q[CMD_COL_LSB +: CMD_COL_W]};
            i_q        <= '0;
            state_q    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (!req) begin
            fb_we_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (accept) begin
            if (last_beat) begin
              fb_we_q <= 1'b0;
              wdone_q <= status_d;
              state_q <= ST_DONE;
            end else begin
              i_q       <= i_q + 1'b1;
              fb_addr_q <= {sel_q, next_off_d};
            end
          end
        end

        ST_DONE: begin
          if (!req) begin
            wdone_q <= '0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          fb_we_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign wdone    = wdone_q;

endmodule

// File: tb/tb_span_fill_engine.sv
// Bench for span_fill_engine: expected pixel writes are queued as each span
// is issued and retired by a monitor on every accepted frame-buffer write;
// each scenario task checks timing, status and handshake behaviour inline.
module tb_span_fill_engine;

  logic        clk;
  logic        reset;
  logic [31:0] data_request;
  logic [7:0]  write_switch;
  logic        buffer_sel;
  logic        fb_ready;
  logic [19:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic [7:0]  wdone;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t expQ[$];
  wr_t expWr;
  int  compared    = 0;
  int  mismatched  = 0;
  int  acceptCount = 0;

  span_fill_engine #(
    .H_RES  (640),
    .V_RES  (480),
    .ADDR_W (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_request (data_request),
    .write_switch (write_switch),
    .buffer_sel   (buffer_sel),
    .fb_ready     (fb_ready),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .fb_we        (fb_we),
    .wdone        (wdone)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write the frame buffer accepts must match the queue head
  always @(negedge clk) begin
    if (!reset && fb_we && fb_ready) begin
      acceptCount++;
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL sb_unexpected_write: got addr=%05h data=%02h, required no write",
                 fb_addr, fb_wdata);
      end else begin
        expWr = expQ.pop_front();
        if ({fb_addr, fb_wdata} !== {expWr.addr, expWr.data}) begin
          mismatched++;
          $display("[TB] FAIL sb_write: got addr=%05h data=%02h, required addr=%05h data=%02h",
                   fb_addr, fb_wdata, expWr.addr, expWr.data);
        end
      end
    end
  end

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkCmd(input int x, input int y, input int len, input int colour);
    return {5'(colour), 8'(len - 1), 9'(y), 10'(x)};
  endfunction

  // Queue the writes a span is expected to produce
  task automatic pushSpan(input int x, input int y, input int n, input logic sel, input int colour);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = {sel, 19'(y * 640 + x + i)};
      w.data = {3'b000, 5'(colour)};
      expQ.push_back(w);
    end
  endtask

  // Clock until wdone becomes non-zero; ticks counts edges from the request edge
  task automatic waitWdone(input int limit, output int ticks, output bit timedOut);
    ticks    = 0;
    timedOut = 1'b1;
    for (int k = 0; k < limit; k++) begin
      tick();
      ticks++;
      if (wdone !== 8'h00) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic releaseReq();
    write_switch = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    data_request = 32'h0;
    write_switch = 8'h00;
    buffer_sel   = 1'b0;
    fb_ready     = 1'b1;
    tick();
    tick();
    compared++;
    if (fb_we !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_we: got %b, required 0", fb_we);
    end
    compared++;
    if (fb_addr !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_addr: got %05h, required 00000", fb_addr);
    end
    compared++;
    if (fb_wdata !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_wdata: got %02h, required 00", fb_wdata);
    end
    compared++;
    if (wdone !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_wdone: got %02h, required 00", wdone);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int          startCount;
    logic        expWe;
    logic [7:0]  expWd;
    logic [19:0] expAddr;
    startCount   = acceptCount;
    data_request = 32'h2818080A;
    buffer_sel   = 1'b1;
    write_switch = 8'h01;
    pushSpan(10, 2, 4, 1'b1, 5);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) begin
        data_request = 32'hFFFF_FFFF;
        buffer_sel   = 1'b0;
      end
      expWe = (t >= 3 && t <= 6);
      compared++;
      if (fb_we !== expWe) begin
        mismatched++;
        $display("[TB] FAIL basic_we_t%0d: got %b, required %b", t, fb_we, expWe);
      end
      if (expWe) begin
        expAddr = 20'h8050A + 20'(t - 3);
        compared++;
        if (fb_addr !== expAddr) begin
          mismatched++;
          $display("[TB] FAIL basic_addr_t%0d: got %05h, required %05h", t, fb_addr, expAddr);
        end
      end
      expWd = (t == 7) ? 8'h01 : 8'h00;
      compared++;
      if (wdone !== expWd) begin
        mismatched++;
        $display("[TB] FAIL basic_wdone_t%0d: got %02h, required %02h", t, wdone, expWd);
      end
    end
    compared++;
    if (acceptCount - startCount != 4) begin
      mismatched++;
      $display("[TB] FAIL basic_count: got %0d, required 4", acceptCount - startCount);
    end
    releaseReq();
    compared++;
    if (wdone !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL basic_clear: got %02h, required 00", wdone);
    end
  endtask

  task automatic test_stall();
    int          startCount;
    logic [7:0]  expWd;
    logic [19:0] expAddr;
    startCount   = acceptCount;
    data_request = 32'h2818080A;
    buffer_sel   = 1'b1;
    write_switch = 8'h01;
    pushSpan(10, 2, 4, 1'b1, 5);
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 5) fb_ready = 1'b0;
      if (t == 7) fb_ready = 1'b1;
      if (t >= 3 && t <= 8) begin
        case (t)
          3:       expAddr = 20'h8050A;
          4:       expAddr = 20'h8050B;
          8:       expAddr = 20'h8050D;
          default: expAddr = 20'h8050C;
        endcase
        compared++;
        if (fb_we !== 1'b1 || fb_addr !== expAddr || fb_wdata !== 8'h05) begin
          mismatched++;
          $display("[TB] FAIL stall_t%0d: got we=%b addr=%05h data=%02h, required we=1 addr=%05h data=05",
                   t, fb_we, fb_addr, fb_wdata, expAddr);
        end
      end
      expWd = (t == 9) ? 8'h01 : 8'h00;
      compared++;
      if (wdone !== expWd) begin
        mismatched++;
        $display("[TB] FAIL stall_wdone_t%0d: got %02h, required %02h", t, wdone, expWd);
      end
    end
    compared++;
    if (acceptCount - startCount != 4) begin
      mismatched++;
      $display("[TB] FAIL stall_count: got %0d, required 4", acceptCount - startCount);
    end
    releaseReq();
  endtask

  task automatic test_clip();
    int ticks;
    bit timedOut;
    data_request = mkCmd(638, 0, 4, 3);
    buffer_sel   = 1'b0;
    write_switch = 8'h01;
    pushSpan(638, 0, 2, 1'b0, 3);
    waitWdone(40, ticks, timedOut);
    compared++;
    if (timedOut || ticks != 5 || wdone !== 8'h03) begin
      mismatched++;
      $display("[TB] FAIL clip_done: got wdone=%02h after %0d edges (timeout=%0b), required 03 after 5",
               wdone, ticks, timedOut);
    end
    releaseReq();
    compared++;
    if (wdone !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL clip_clear: got %02h, required 00", wdone);
    end
  endtask

  task automatic test_reject();
    int ticks;
    bit timedOut;
    int startCount;
    startCount   = acceptCount;
    data_request = mkCmd(5, 480, 10, 9);
    buffer_sel   = 1'b1;
    write_switch = 8'h01;
    waitWdone(40, ticks, timedOut);
    compared++;
    if (timedOut || ticks != 3 || wdone !== 8'h05) begin
      mismatched++;
      $display("[TB] FAIL reject_done: got wdone=%02h after %0d edges (timeout=%0b), required 05 after 3",
               wdone, ticks, timedOut);
    end
    tick();
    compared++;
    if (fb_we !== 1'b0 || acceptCount != startCount) begin
      mismatched++;
      $display("[TB] FAIL reject_writes: got we=%b writes=%0d, required we=0 writes=0",
               fb_we, acceptCount - startCount);
    end
    releaseReq();
  endtask

  task automatic test_abort();
    int startCount;
    int ticks;
    bit timedOut;
    startCount   = acceptCount;
    data_request = 32'h2818080A;
    buffer_sel   = 1'b1;
    write_switch = 8'h01;
    pushSpan(10, 2, 4, 1'b1, 5);
    repeat (4) tick();
    write_switch = 8'h00;
    for (int t = 5; t <= 8; t++) begin
      tick();
      compared++;
      if (fb_we !== 1'b0 || wdone !== 8'h00) begin
        mismatched++;
        $display("[TB] FAIL abort_quiet_t%0d: got we=%b wdone=%02h, required we=0 wdone=00",
                 t, fb_we, wdone);
      end
    end
    compared++;
    if (acceptCount - startCount != 2 || expQ.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL abort_count: got %0d writes %0d pending, required 2 writes 2 pending",
               acceptCount - startCount, expQ.size());
    end
    expQ.delete();
    data_request = mkCmd(10, 2, 4, 17);
    write_switch = 8'h01;
    pushSpan(10, 2, 4, 1'b1, 17);
    waitWdone(40, ticks, timedOut);
    compared++;
    if (timedOut || ticks != 7 || wdone !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL abort_next: got wdone=%02h after %0d edges (timeout=%0b), required 01 after 7",
               wdone, ticks, timedOut);
    end
    releaseReq();
  endtask

  task automatic test_reset_mid_span();
    int startCount;
    int ticks;
    bit timedOut;
    startCount   = acceptCount;
    data_request = mkCmd(100, 10, 8, 7);
    buffer_sel   = 1'b0;
    write_switch = 8'h01;
    pushSpan(100, 10, 8, 1'b0, 7);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    compared++;
    if (fb_we !== 1'b0 || fb_addr !== 20'h0 || fb_wdata !== 8'h0 || wdone !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_outputs: got we=%b addr=%05h data=%02h wdone=%02h, required all 0",
               fb_we, fb_addr, fb_wdata, wdone);
    end
    write_switch = 8'h00;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      compared++;
      if (fb_we !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rst_no_resume_%0d: got we=%b, required 0", t, fb_we);
      end
    end
    compared++;
    if (acceptCount - startCount != 1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_count: got %0d, required 1", acceptCount - startCount);
    end
    expQ.delete();
    data_request = mkCmd(639, 479, 1, 31);
    buffer_sel   = 1'b1;
    write_switch = 8'h01;
    pushSpan(639, 479, 1, 1'b1, 31);
    waitWdone(40, ticks, timedOut);
    compared++;
    if (timedOut || ticks != 4 || wdone !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_next: got wdone=%02h after %0d edges (timeout=%0b), required 01 after 4",
               wdone, ticks, timedOut);
    end
    releaseReq();
  endtask

  task automatic test_back_to_back();
    int         x, y, len, colour, effLen, ticks;
    bit         timedOut;
    logic       sel;
    logic [7:0] expWd;
    for (int n = 0; n < 5; n++) begin
      if (n == 0) begin
        x = 600; y = 300; len = 256;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
        len = $urandom_range(1, 256);
      end
      colour = $urandom_range(0, 31);
      sel    = 1'($urandom_range(0, 1));
      effLen = (640 - x < len) ? 640 - x : len;
      expWd  = (effLen < len) ? 8'h03 : 8'h01;
      pushSpan(x, y, effLen, sel, colour);
      data_request = mkCmd(x, y, len, colour);
      buffer_sel   = sel;
      write_switch = 8'h01;
      waitWdone(400, ticks, timedOut);
      compared++;
      if (timedOut || ticks != 3 + effLen || wdone !== expWd) begin
        mismatched++;
        $display("[TB] FAIL b2b_%0d: got wdone=%02h after %0d edges (timeout=%0b), required %02h after %0d",
                 n, wdone, ticks, timedOut, expWd, 3 + effLen);
      end
      releaseReq();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clip();
    test_reject();
    test_abort();
    test_reset_mid_span();
    test_back_to_back();
    tick();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_drain: got %0d pending writes, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
